// File: rtl/mig_stream_evaluator.sv
`default_nettype none
// ============================================================================
// Module      : mig_stream_evaluator
// Description : Sequential evaluator for a majority-inverter graph delivered
//               as a topologically ordered stream of 3-input majority nodes.
//               Each node is evaluated against a captured primary-input
//               vector; the value of the node flagged last is returned.
// Ports       : clk, rst_n       clock, synchronous active-low reset
//               i_start          begin evaluation, samples i_pi_vec
//               i_pi_vec         primary inputs (bit k = signal index k+1)
//               i_node_*         node record (valid, a/b/c index, inv, last)
//               o_node_ready     node record accepted when valid && ready
//               o_po_valid       one-cycle pulse, o_po_value valid
//               o_po_value       evaluated output, held until next completion
//               o_busy           evaluation in progress
//               o_err            sticky error, cleared by i_start
// Revision    : 1.0 - initial release
// ============================================================================
module mig_stream_evaluator #(
   parameter int NUM_PI    = 18,
   parameter int MAX_NODES = 16,
   parameter int IDX_W     = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [NUM_PI-1:0] i_pi_vec,
   input  logic              i_node_valid,
   output logic              o_node_ready,
   input  logic [IDX_W-1:0]  i_node_a,
   input  logic [IDX_W-1:0]  i_node_b,
   input  logic [IDX_W-1:0]  i_node_c,
   input  logic [2:0]        i_node_inv,
   input  logic              i_node_last,
   output logic              o_po_valid,
   output logic              o_po_value,
   output logic              o_busy,
   output logic              o_err
);

   localparam int C_SIG_W = 1 + NUM_PI + MAX_NODES;
   localparam int C_CNT_W = $clog2(MAX_NODES + 1);
   localparam int C_LIM_W = IDX_W + 1;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [NUM_PI-1:0]    r_pi;
   logic [MAX_NODES-1:0] r_nodes;
   logic [C_CNT_W-1:0]   r_count;
   logic                 r_err;
   logic                 r_po_valid;
   logic                 r_po_value;

   logic                 w_run;
   logic                 w_hs;
   logic                 w_bad;
   logic                 w_store;
   logic                 w_idle_start;
   logic [C_LIM_W-1:0]   w_limit;
   logic [C_SIG_W-1:0]   w_sig;
   logic                 w_xa;
   logic                 w_xb;
   logic                 w_xc;
   logic                 w_v;

   // Select one bit of the signal space; indices beyond it read as 0 (they
   // are always flagged as errors, so the value is never used).
   function automatic logic f_lookup(input logic [IDX_W-1:0]   idx,
                                     input logic [C_SIG_W-1:0] sig);
      logic r;
      r = 1'b0;
      for (int k = 0; k < C_SIG_W; k++) begin
         if (idx == IDX_W'(k)) r = sig[k];
      end
      return r;
   endfunction

   // Signal space: index 0 = constant 0, then PIs, then stored nodes.
   assign w_sig   = {r_nodes, r_pi, 1'b0};

   assign w_run        = (r_state == S_RUN);
   assign w_hs         = i_node_valid && w_run;
   assign w_idle_start = (r_state == S_IDLE) && i_start;

   // First index not yet defined: anything at or above it is a forward
   // reference or out of range.
   assign w_limit = C_LIM_W'(NUM_PI + 1) + C_LIM_W'(r_count);
   assign w_bad   = ({1'b0, i_node_a} >= w_limit) ||
                    ({1'b0, i_node_b} >= w_limit) ||
                    ({1'b0, i_node_c} >= w_limit) ||
                    (r_count == C_CNT_W'(MAX_NODES));
   assign w_store = w_hs && !w_bad;

   assign w_xa = f_lookup(i_node_a, w_sig) ^ i_node_inv[0];
   assign w_xb = f_lookup(i_node_b, w_sig) ^ i_node_inv[1];
   assign w_xc = f_lookup(i_node_c, w_sig) ^ i_node_inv[2];
   assign w_v  = (w_xa & w_xb) | (w_xa & w_xc) | (w_xb & w_xc);

   always_comb begin
      w_state_next = r_state;
      o_node_ready = 1'b0;
      o_busy       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) w_state_next = S_RUN;
         end
         S_RUN: begin
            o_node_ready = 1'b1;
            o_busy       = 1'b1;
            if (w_hs && (w_bad || i_node_last)) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_count    <= '0;
         r_err      <= 1'b0;
         r_po_valid <= 1'b0;
         r_po_value <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_po_valid <= 1'b0;
         if (w_idle_start) begin
            r_count <= '0;
            r_err   <= 1'b0;
         end
         if (w_hs) begin
            if (w_bad) begin
               r_err <= 1'b1;
            end else begin
               r_count <= r_count + C_CNT_W'(1);
               if (i_node_last) begin
                  r_po_valid <= 1'b1;
                  r_po_value <= w_v;
               end
            end
         end
      end
   end

   // Data storage needs no reset: every location is written before it
   // can legally be referenced.
   always_ff @(posedge clk) begin
      if (w_idle_start) r_pi <= i_pi_vec;
      for (int n = 0; n < MAX_NODES; n++) begin
         if (w_store && (r_count == C_CNT_W'(n))) r_nodes[n] <= w_v;
      end
   end

   assign o_po_valid = r_po_valid;
   assign o_po_value = r_po_value;
   assign o_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mig_stream_evaluator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mig_stream_evaluator
// Description : Self-checking bench for mig_stream_evaluator with a
//               behavioural graph model and randomized node streams.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mig_stream_evaluator;

   localparam int NPI  = 18;
   localparam int MAXN = 16;
   localparam int IW   = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_start;
   logic [NPI-1:0] i_pi_vec;
   logic          i_node_valid;
   logic          o_node_ready;
   logic [IW-1:0] i_node_a;
   logic [IW-1:0] i_node_b;
   logic [IW-1:0] i_node_c;
   logic [2:0]    i_node_inv;
   logic          i_node_last;
   logic          o_po_valid;
   logic          o_po_value;
   logic          o_busy;
   logic          o_err;

   int errors = 0;
   int checks = 0;

   // Stream description used by the driver and the model.
   int         nn;
   logic [5:0] na   [0:MAXN];
   logic [5:0] nb   [0:MAXN];
   logic [5:0] nc   [0:MAXN];
   logic [2:0] ninv [0:MAXN];
   int         hs_cnt;
   logic       exp_po = 1'b0;

   mig_stream_evaluator #(.NUM_PI(NPI), .MAX_NODES(MAXN), .IDX_W(IW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_start      (i_start),
      .i_pi_vec     (i_pi_vec),
      .i_node_valid (i_node_valid),
      .o_node_ready (o_node_ready),
      .i_node_a     (i_node_a),
      .i_node_b     (i_node_b),
      .i_node_c     (i_node_c),
      .i_node_inv   (i_node_inv),
      .i_node_last  (i_node_last),
      .o_po_valid   (o_po_valid),
      .o_po_value   (o_po_value),
      .o_busy       (o_busy),
      .o_err        (o_err)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Graph semantics: signal 0 = 0, 1..NPI = PIs, NPI+1+k = node k.
   function automatic void model(input logic [NPI-1:0] pi, output logic v, output logic er);
      logic sig [0:63];
      int   lim;
      int   ones;
      for (int i = 0; i < 64; i++) sig[i] = 1'b0;
      for (int i = 0; i < NPI; i++) sig[i+1] = pi[i];
      v  = 1'b0;
      er = 1'b0;
      for (int k = 0; k < nn; k++) begin
         if (!er) begin
            lim = NPI + 1 + k;
            if (k >= MAXN || int'(na[k]) >= lim || int'(nb[k]) >= lim || int'(nc[k]) >= lim) begin
               er = 1'b1;
            end else begin
               ones = int'(sig[na[k]] ^ ninv[k][0]) + int'(sig[nb[k]] ^ ninv[k][1])
                    + int'(sig[nc[k]] ^ ninv[k][2]);
               sig[lim] = (ones >= 2);
               v = sig[lim];
            end
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [NPI-1:0] pi);
      i_start  = 1'b1;
      i_pi_vec = pi;
      tick();
      i_start  = 1'b0;
      i_pi_vec = NPI'($urandom);
   endtask

   // Streams nodes back to back with valid held high; last flag on final node.
   task automatic send_stream();
      hs_cnt = 0;
      for (int k = 0; k < nn; k++) begin
         i_node_valid = 1'b1;
         i_node_a     = na[k];
         i_node_b     = nb[k];
         i_node_c     = nc[k];
         i_node_inv   = ninv[k];
         i_node_last  = (k == nn - 1);
         if (o_node_ready) hs_cnt++;
         tick();
      end
      i_node_valid = 1'b0;
      i_node_last  = 1'b0;
   endtask

   task automatic run_stream(input logic [NPI-1:0] pi, output logic pv, output logic val,
                             output logic ef, output logic rdy, output logic pv2);
      do_start(pi);
      send_stream();
      pv  = o_po_valid;
      val = o_po_value;
      ef  = o_err;
      rdy = o_node_ready;
      tick();
      pv2 = o_po_valid;
   endtask

   task automatic set_node(input int k, input int a, input int b, input int c, input int inv);
      na[k]   = 6'(a);
      nb[k]   = 6'(b);
      nc[k]   = 6'(c);
      ninv[k] = 3'(inv);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if ({o_node_ready, o_busy, o_po_valid, o_po_value, o_err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 00000",
                  {o_node_ready, o_busy, o_po_valid, o_po_value, o_err});
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (o_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_busy: got %b expected 0", o_busy);
      end
   endtask

   task automatic test_t1_t2();
      logic pv, val, ef, rdy, pv2;
      nn = 1;
      set_node(0, 1, 2, 3, 0);
      run_stream(18'b011, pv, val, ef, rdy, pv2);
      checks++;
      if ({pv, val, pv2} !== 3'b110) begin
         errors++;
         $display("FAIL t1_maj: got pv/val/pv_next=%b%b%b expected 110", pv, val, pv2);
      end
      exp_po = 1'b1;
      ninv[0] = 3'b111;
      run_stream(18'b011, pv, val, ef, rdy, pv2);
      checks++;
      if ({pv, val, pv2, o_busy} !== 4'b1000) begin
         errors++;
         $display("FAIL t2_inv: got pv/val/pv_next/busy=%b%b%b%b expected 1000", pv, val, pv2, o_busy);
      end
      exp_po = 1'b0;
   endtask

   task automatic test_t3_const();
      logic pv, val, ef, rdy, pv2;
      nn = 1;
      set_node(0, 0, 1, 2, 1);
      for (int p = 0; p < 4; p++) begin
         run_stream(NPI'(p), pv, val, ef, rdy, pv2);
         exp_po = (p != 0);
         checks++;
         if (pv !== 1'b1 || val !== exp_po) begin
            errors++;
            $display("FAIL t3_const1 p=%0d: got pv=%b val=%b expected pv=1 val=%b", p, pv, val, exp_po);
         end
      end
   endtask

   task automatic test_chain();
      logic pv, val, ef, rdy, pv2, mv, me;
      logic [NPI-1:0] pi;
      nn = 4;
      for (int it = 0; it < 1000; it++) begin
         set_node(0, $urandom_range(1, NPI), $urandom_range(1, NPI), $urandom_range(1, NPI),
                  $urandom_range(0, 7));
         for (int k = 1; k < 4; k++)
            set_node(k, NPI + k, $urandom_range(0, NPI + k), $urandom_range(0, NPI + k),
                     $urandom_range(0, 7));
         pi = NPI'($urandom);
         model(pi, mv, me);
         run_stream(pi, pv, val, ef, rdy, pv2);
         checks++;
         if (pv !== 1'b1 || val !== mv || ef !== 1'b0 || hs_cnt != 4) begin
            errors++;
            $display("FAIL chain it=%0d: got pv=%b val=%b err=%b hs=%0d expected 1 %b 0 4",
                     it, pv, val, ef, hs_cnt, mv);
         end
         exp_po = mv;
      end
   endtask

   task automatic test_fwd_ref();
      logic pv, val, ef, rdy, pv2;
      nn = 1;
      set_node(0, NPI + 1, 1, 2, 0);
      run_stream(NPI'($urandom), pv, val, ef, rdy, pv2);
      checks++;
      if ({ef, pv, rdy, pv2, val} !== {4'b1000, exp_po}) begin
         errors++;
         $display("FAIL fwd_ref: got err/pv/rdy/pv_next/val=%b%b%b%b%b expected 1000%b",
                  ef, pv, rdy, pv2, val, exp_po);
      end
      do_start(18'b1);
      checks++;
      if (o_err !== 1'b0 || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL err_clear: got err=%b busy=%b expected 0 1", o_err, o_busy);
      end
      // Second node referring to its own index is also a forward reference.
      nn = 2;
      set_node(0, 1, 1, 1, 0);
      set_node(1, NPI + 2, 1, 1, 0);
      send_stream();
      checks++;
      if (o_err !== 1'b1 || o_po_valid !== 1'b0 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL self_ref: got err=%b pv=%b busy=%b expected 1 0 0", o_err, o_po_valid, o_busy);
      end
   endtask

   task automatic test_overflow();
      logic pv, val, ef, rdy, pv2, mv, me;
      logic [NPI-1:0] pi;
      set_node(0, 1, 2, 3, $urandom_range(0, 7));
      for (int k = 1; k <= MAXN; k++)
         set_node(k, NPI + k, $urandom_range(1, NPI), $urandom_range(0, NPI + k), $urandom_range(0, 7));
      nn = MAXN;
      pi = NPI'($urandom);
      model(pi, mv, me);
      run_stream(pi, pv, val, ef, rdy, pv2);
      checks++;
      if (pv !== 1'b1 || val !== mv || ef !== 1'b0 || me !== 1'b0) begin
         errors++;
         $display("FAIL full_depth: got pv=%b val=%b err=%b expected 1 %b 0", pv, val, ef, mv);
      end
      exp_po = mv;
      nn = MAXN + 1;
      run_stream(pi, pv, val, ef, rdy, pv2);
      checks++;
      if (ef !== 1'b1 || pv !== 1'b0 || rdy !== 1'b0 || val !== exp_po) begin
         errors++;
         $display("FAIL overflow: got err=%b pv=%b rdy=%b val=%b expected 1 0 0 %b", ef, pv, rdy, val, exp_po);
      end
   endtask

   task automatic test_random_graphs();
      logic pv, val, ef, rdy, pv2, mv, me;
      logic [NPI-1:0] pi;
      for (int it = 0; it < 300; it++) begin
         nn = $urandom_range(1, MAXN + 1);
         for (int k = 0; k < nn; k++)
            set_node(k, $urandom_range(0, NPI + k + ((k % 5 == 4) ? 1 : 0)),
                     $urandom_range(0, NPI + k), $urandom_range(0, NPI + k), $urandom_range(0, 7));
         pi = NPI'($urandom);
         model(pi, mv, me);
         run_stream(pi, pv, val, ef, rdy, pv2);
         if (!me) exp_po = mv;
         checks++;
         if (pv !== !me || ef !== me || val !== exp_po || pv2 !== 1'b0) begin
            errors++;
            $display("FAIL random it=%0d n=%0d: got pv=%b err=%b val=%b expected %b %b %b",
                     it, nn, pv, ef, val, !me, me, exp_po);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      logic pv, val, ef, rdy, pv2;
      nn = 1;
      set_node(0, 1, 2, 3, 0);
      run_stream(18'b011, pv, val, ef, rdy, pv2);
      do_start(18'b011);
      for (int k = 0; k < 2; k++) begin
         i_node_valid = 1'b1;
         i_node_a = 6'd1; i_node_b = 6'd2; i_node_c = 6'd3; i_node_inv = 3'd0; i_node_last = 1'b0;
         tick();
      end
      i_node_last = 1'b1;
      rst_n = 1'b0;
      tick();
      checks++;
      if ({o_node_ready, o_busy, o_po_valid, o_po_value, o_err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_mid_run: got %b expected 00000",
                  {o_node_ready, o_busy, o_po_valid, o_po_value, o_err});
      end
      rst_n = 1'b1;
      tick();
      i_node_valid = 1'b0;
      i_node_last  = 1'b0;
      checks++;
      if (o_busy !== 1'b0 || o_po_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_stays_idle: got busy=%b pv=%b expected 0 0", o_busy, o_po_valid);
      end
      set_node(0, 40, 1, 1, 0);
      run_stream(18'b1, pv, val, ef, rdy, pv2);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if (ef !== 1'b1 || o_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_clears_err: got before=%b after=%b expected 1 0", ef, o_err);
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      i_start      = 1'b0;
      i_pi_vec     = '0;
      i_node_valid = 1'b0;
      i_node_a     = '0;
      i_node_b     = '0;
      i_node_c     = '0;
      i_node_inv   = '0;
      i_node_last  = 1'b0;
      nn           = 0;
      hs_cnt       = 0;
      test_reset();
      test_t1_t2();
      test_t3_const();
      test_chain();
      test_fwd_ref();
      test_overflow();
      test_random_graphs();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
